// File: rtl/direction_pointer_if.sv
// Bin handshake between the direction binner (master) and the servo pointer (slave).
interface direction_pointer_if;
  logic       bin_valid_in;
  logic [4:0] bin_in;
  logic       bin_ready_out;

  modport master (output bin_valid_in, output bin_in, input bin_ready_out);
  modport slave  (input bin_valid_in, input bin_in, output bin_ready_out);
endinterface

// File: rtl/direction_pointer.sv
// Converts accepted direction bins into a slew-limited hobby-servo PWM and
// holds the binner off (ready low) until the servo has reached the target.
module direction_pointer #(
  parameter int unsigned PWM_PERIOD_CYCLES = 1966080,
  parameter int unsigned PULSE_MIN_CYCLES  = 98304,
  parameter int unsigned PULSE_STEP_CYCLES = 6144,
  parameter int unsigned SLEW_CYCLES       = 12288
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  direction_pointer_if.slave         bin_if,
  output logic                       pwm_out,
  output logic [3:0]                 position_out,
  output logic                       moving_out
);

  localparam int CW = $clog2(PWM_PERIOD_CYCLES);

  localparam logic [0:0] READY = 1'b0;
  localparam logic [0:0] BUSY  = 1'b1;

  logic [0:0]    r_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_cur;
  logic [CW-1:0] r_target;
  logic [3:0]    r_target_bin;
  logic [3:0]    r_position;
  logic          r_ready;
  logic          r_moving;
  logic          r_pwm;

  logic          w_frame_end;
  logic          w_xfer;
  logic [CW-1:0] w_bin_target;
  logic          w_up;
  logic [CW-1:0] w_diff;
  logic [CW-1:0] w_next_width;

  assign w_frame_end  = (r_count == CW'(PWM_PERIOD_CYCLES - 1));
  assign w_xfer       = bin_if.bin_valid_in && r_ready && (r_state == READY);
  assign w_bin_target = CW'(PULSE_MIN_CYCLES) + CW'(bin_if.bin_in[3:0]) * CW'(PULSE_STEP_CYCLES);

  // Width for the next frame: snap to target when within one slew step,
  // otherwise move one full step toward it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_up         = (r_target > r_cur);
    w_diff       = w_up ? (r_target - r_cur) : (r_cur - r_target);
    w_next_width = r_target;
    if (32'(w_diff) > SLEW_CYCLES) begin
      w_next_width = w_up ? (r_cur + CW'(SLEW_CYCLES)) : (r_cur - CW'(SLEW_CYCLES));
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= READY;
      r_count      <= '0;
      r_cur        <= CW'(PULSE_MIN_CYCLES);
      r_target     <= CW'(PULSE_MIN_CYCLES);
      r_target_bin <= '0;
      r_position   <= '0;
      r_ready      <= 1'b0;
      r_moving     <= 1'b0;
      r_pwm        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
      r_count <= w_frame_end ? '0 : r_count + CW'(1);
      r_pwm   <= (r_count < r_cur);

      case (r_state)
        READY: begin
          if (w_xfer && !bin_if.bin_in[4]) begin
            r_target     <= w_bin_target;
            r_target_bin <= bin_if.bin_in[3:0];
            r_state      <= BUSY;
            r_ready      <= 1'b0;
            r_moving     <= 1'b1;
          end else begin
            r_ready <= 1'b1;
          end
        end
        BUSY: begin
          // Width only changes at frame end so no frame carries a partial pulse.
          if (w_frame_end) begin
            r_cur <= w_next_width;
            if (w_next_width == r_target) begin
              r_state    <= READY;
              r_ready    <= 1'b1;
              r_moving   <= 1'b0;
              r_position <= r_target_bin;
            end
          end
        end
        default: r_state <= READY;
      endcase
    end
  end

  assign bin_if.bin_ready_out = r_ready;
  assign pwm_out              = r_pwm;
  assign position_out         = r_position;
  assign moving_out           = r_moving;

endmodule

// File: tb/tb_direction_pointer.sv
// Randomized and directed bench for direction_pointer against a per-cycle
// integer rules model plus pulse-length measurements of the PWM output.
module tb_direction_pointer;

  localparam int P    = 100;
  localparam int MIN  = 10;
  localparam int STEP = 4;
  localparam int SLEW = 8;

  logic       clk_in;
  logic       rst_n_in;
  logic       pwm_out;
  logic [3:0] position_out;
  logic       moving_out;

  direction_pointer_if bif ();

  direction_pointer #(
    .PWM_PERIOD_CYCLES (P),
    .PULSE_MIN_CYCLES  (MIN),
    .PULSE_STEP_CYCLES (STEP),
    .SLEW_CYCLES       (SLEW)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .bin_if       (bif.slave),
    .pwm_out      (pwm_out),
    .position_out (position_out),
    .moving_out   (moving_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: frame counter, current/target width in plain integers.
  int m_cnt, m_cur, m_tgt, m_tbin, m_pos;
  bit m_busy, m_ready, m_pwm;

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_cnt = 0; m_cur = MIN; m_tgt = MIN; m_tbin = 0; m_pos = 0;
      m_busy = 0; m_ready = 0; m_pwm = 0;
    end else begin
      m_pwm = (m_cnt < m_cur);
      if (m_busy) begin
        if (m_cnt == P - 1) begin
          int d;
          d = m_tgt - m_cur;
          if (d <= SLEW && d >= -SLEW) m_cur = m_tgt;
          else m_cur = m_cur + ((d > 0) ? SLEW : -SLEW);
          if (m_cur == m_tgt) begin
            m_busy = 0; m_ready = 1; m_pos = m_tbin;
          end
        end
      end else if (bif.bin_valid_in && m_ready && !bif.bin_in[4]) begin
        m_tgt = MIN + int'(bif.bin_in[3:0]) * STEP;
        m_tbin = int'(bif.bin_in[3:0]);
        m_busy = 1; m_ready = 0;
      end else begin
        m_ready = 1;
      end
      m_cnt = (m_cnt + 1) % P;
    end
  end

  // Every cycle, all outputs against the model.
  always @(negedge clk_in) begin
    logic [6:0] exp_v;
    exp_v = {m_ready, m_busy, 4'(m_pos), m_pwm};
    check("cycle_outputs", {25'd0, bif.bin_ready_out, moving_out, position_out, pwm_out}, {25'd0, exp_v});
  end

  // High-pulse length monitor and transfer counter.
  int q_runs[$];
  int run_len = 0;
  int xfers   = 0;

  always @(negedge clk_in) begin
    if (!rst_n_in) run_len = 0;
    else if (pwm_out) run_len++;
    else if (run_len != 0) begin
      q_runs.push_back(run_len);
      run_len = 0;
    end
  end

  always @(posedge clk_in)
    if (rst_n_in && bif.bin_valid_in && bif.bin_ready_out) xfers++;

  task automatic send(input logic [4:0] b, input int hold);
    bif.bin_valid_in = 1'b1;
    bif.bin_in       = b;
    repeat (hold) @(negedge clk_in);
    bif.bin_valid_in = 1'b0;
    bif.bin_in       = 5'd0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(bif.bin_ready_out && !moving_out) && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 32'(n), 32'(budget - 1));
  endtask

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    while (m_cnt != v && n < 2 * P) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 2 * P) check("count_align_timeout", 32'(n), 0);
  endtask

  task automatic check_steady(input string tag, input int w);
    q_runs.delete();
    repeat (2 * P + 50) @(negedge clk_in);
    check({tag, "_nruns"}, 32'(q_runs.size() >= 2), 1);
    if (q_runs.size() >= 2) check({tag, "_width"}, 32'(q_runs[q_runs.size() - 1]), 32'(w));
  endtask

  initial begin
    int exp_w, base, b, hold;
    logic [4:0] rb;

    rst_n_in         = 1'b0;
    bif.bin_valid_in = 1'b0;
    bif.bin_in       = 5'd0;

    // Reset sequence
    repeat (5) @(negedge clk_in);
    check("rst_ready", 32'(bif.bin_ready_out), 0);
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_position", 32'(position_out), 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("ready_after_release", 32'(bif.bin_ready_out), 1);
    check_steady("reset_width", MIN);

    // Small move to bin 2
    send(5'd2, 1);
    check("small_ready_low", 32'(bif.bin_ready_out), 0);
    check("small_moving", 32'(moving_out), 1);
    wait_idle("small", 3 * P);
    check("small_position", 32'(position_out), 2);
    check_steady("small_width", MIN + 2 * STEP);

    // Back to bin 0, then long slew to bin 15
    send(5'd0, 1);
    wait_idle("home", 3 * P);
    wait_cnt(50);
    send(5'd15, 1);
    q_runs.delete();
    wait_idle("long", 12 * P);
    check("long_position", 32'(position_out), 15);
    repeat (P) @(negedge clk_in);
    exp_w = MIN;
    base  = 0;
    check("long_nruns", 32'(q_runs.size() >= 8), 1);
    while (exp_w != MIN + 15 * STEP && base < q_runs.size()) begin
      exp_w = (exp_w + SLEW > MIN + 15 * STEP) ? MIN + 15 * STEP : exp_w + SLEW;
      check($sformatf("long_frame%0d", base), 32'(q_runs[base]), 32'(exp_w));
      base++;
    end
    check("long_frames", 32'(base), 8);

    // Sticky valid: bin 4 held three cycles
    base = xfers;
    bif.bin_valid_in = 1'b1;
    bif.bin_in       = 5'd4;
    @(negedge clk_in);
    check("sticky_ready_c2", 32'(bif.bin_ready_out), 0);
    repeat (2) @(negedge clk_in);
    bif.bin_valid_in = 1'b0;
    check("sticky_one_xfer", 32'(xfers - base), 1);
    wait_idle("sticky", 10 * P);
    check("sticky_position", 32'(position_out), 4);
    check_steady("sticky_width", MIN + 4 * STEP);

    // Invalid bin is consumed and discarded
    base = xfers;
    send(5'd16, 1);
    check("invalid_xfer", 32'(xfers - base), 1);
    check("invalid_ready", 32'(bif.bin_ready_out), 1);
    check("invalid_moving", 32'(moving_out), 0);
    check("invalid_position", 32'(position_out), 4);
    check_steady("invalid_width", MIN + 4 * STEP);

    // Randomized moves, including invalid bins and held valids
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk_in);
      b    = $urandom_range(0, 15);
      rb   = ($urandom_range(0, 3) == 0) ? 5'(16 + b) : 5'(b);
      hold = $urandom_range(1, 3);
      wait_idle("rand_pre", 12 * P);
      send(rb, hold);
      wait_idle("rand", 12 * P);
      if (!rb[4]) check($sformatf("rand%0d_position", i), 32'(position_out), 32'(b));
    end

    // Reset during the third frame of a move to bin 15
    send(5'd0, 1);
    wait_idle("home2", 12 * P);
    wait_cnt(50);
    send(5'd15, 1);
    for (int f = 0; f < 3; f++) begin
      @(negedge clk_in);
      wait_cnt(20);
    end
    check("midslew_pwm_high", 32'(pwm_out), 1);
    #2 rst_n_in = 1'b0;
    #1;
    check("midslew_rst_pwm", 32'(pwm_out), 0);
    check("midslew_rst_ready", 32'(bif.bin_ready_out), 0);
    check("midslew_rst_moving", 32'(moving_out), 0);
    repeat (5) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("midslew_ready_release", 32'(bif.bin_ready_out), 1);
    check_steady("midslew_home_width", MIN);
    check("midslew_position", 32'(position_out), 0);
    send(5'd3, 1);
    check("midslew_accept", 32'(moving_out), 1);
    wait_idle("after_rst", 3 * P);
    check("after_rst_position", 32'(position_out), 3);
    check_steady("after_rst_width", MIN + 3 * STEP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
